// File: rtl/div_sequencer_if.sv
// Configuration, control and tick-output bundle for the divider-chain sequencer.
interface div_sequencer_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LEVELs = 3,
    parameter int unsigned NCNT_W = 8
);
    logic              CFG_VALID;
    logic              CFG_READY;
    logic [CNT_W-1:0]  CFG_DIV;
    logic              CFG_MODE;
    logic [NCNT_W-1:0] CFG_COUNT;
    logic              START;
    logic              STOP;
    logic              TICK;
    logic [LEVELs-1:0] TAP_OUT;
    logic              BUSY;
    logic              DONE;

    // Driver side: offers configuration and start/stop, observes the time base.
    modport master (
        output CFG_VALID, CFG_DIV, CFG_MODE, CFG_COUNT, START, STOP,
        input  CFG_READY, TICK, TAP_OUT, BUSY, DONE
    );

    // Sequencer side.
    modport slave (
        input  CFG_VALID, CFG_DIV, CFG_MODE, CFG_COUNT, START, STOP,
        output CFG_READY, TICK, TAP_OUT, BUSY, DONE
    );
endinterface

// File: rtl/div_sequencer.sv
// Time-base sequencer: programmable prescaler producing a one-cycle TICK enable
// per period, a wrapping tick counter (TAP_OUT) and a one-shot mode of N ticks.
module div_sequencer #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LEVELs = 3,
    parameter int unsigned NCNT_W = 8
) (
    input logic            CLK_IN,
    input logic            RST,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  div_q;
    logic              mode_q;
    logic [NCNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]  presc_q;
    logic [NCNT_W-1:0] rem_q;
    logic [LEVELs-1:0] tap_q;

    logic              tick_c;
    logic              eff_mode;
    logic [NCNT_W-1:0] eff_cnt;
    logic              last_tick;

    // Period end: prescaler has reached the programmed ratio while running.
    assign tick_c    = (state_q == S_RUN) && (presc_q == div_q);
    assign last_tick = tick_c && mode_q && (rem_q == NCNT_W'(1));

    // A configuration accepted in the same cycle as START applies to that run.
    assign eff_mode = bus.CFG_VALID ? bus.CFG_MODE  : mode_q;
    assign eff_cnt  = bus.CFG_VALID ? bus.CFG_COUNT : cnt_q;

    assign bus.TICK      = tick_c;
    assign bus.TAP_OUT   = tap_q;
    assign bus.CFG_READY = (state_q == S_IDLE);
    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = (state_q == S_DONE);

    // Sequencer state, configuration registers, prescaler and tick counters.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            presc_q <= '0;
            rem_q   <= '0;
            tap_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.CFG_VALID) begin
                        div_q  <= bus.CFG_DIV;
                        mode_q <= bus.CFG_MODE;
                        cnt_q  <= bus.CFG_COUNT;
                    end
                    if (bus.START && !bus.STOP) begin
                        presc_q <= '0;
                        tap_q   <= '0;
                        rem_q   <= eff_cnt;
                        // A one-shot of zero ticks completes without running.
                        if (eff_mode && (eff_cnt == '0)) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (tick_c) begin
                        presc_q <= '0;
                        tap_q   <= tap_q + LEVELs'(1);
                        if (mode_q) begin
                            rem_q <= rem_q - NCNT_W'(1);
                        end
                    end else begin
                        presc_q <= presc_q + CNT_W'(1);
                    end
                    // Abort takes priority over one-shot completion.
                    if (bus.STOP) begin
                        state_q <= S_IDLE;
                    end else if (last_tick) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer.
module tb_div_sequencer;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LEVELs = 3;
    localparam int unsigned NCNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    div_sequencer_if #(.CNT_W(CNT_W), .LEVELs(LEVELs), .NCNT_W(NCNT_W)) bus ();

    div_sequencer #(.CNT_W(CNT_W), .LEVELs(LEVELs), .NCNT_W(NCNT_W)) dut (
        .CLK_IN (clk),
        .RST    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.CFG_VALID = 1'b0;
        bus.CFG_DIV   = '0;
        bus.CFG_MODE  = 1'b0;
        bus.CFG_COUNT = '0;
        bus.START     = 1'b0;
        bus.STOP      = 1'b0;
    endtask

    task automatic configure(input logic [CNT_W-1:0] div, input logic mode,
                             input logic [NCNT_W-1:0] cnt);
        bus.CFG_VALID = 1'b1;
        bus.CFG_DIV   = div;
        bus.CFG_MODE  = mode;
        bus.CFG_COUNT = cnt;
        step();
        idle_inputs();
    endtask

    // START in cycle 0; returns in cycle 1.
    task automatic do_start();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    task automatic do_stop();
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.CFG_VALID = 1'b1;
            bus.CFG_DIV   = 16'h0002;
            bus.CFG_MODE  = i[0];
            bus.CFG_COUNT = 8'd4;
            bus.START     = ~i[0];
            bus.STOP      = i[0];
            step();
        end
        rst = 1'b0;
        idle_inputs();
        checks++; if (bus.TICK !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", bus.TICK); end
        checks++; if (bus.TAP_OUT !== 3'd0) begin fails++; $display("FAIL reset_tap got %0d exp 0", bus.TAP_OUT); end
        checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.BUSY); end
        checks++; if (bus.CFG_READY !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.CFG_READY); end
    endtask

    // DIV=3 continuous, STOP in cycle 21 leaves TAP_OUT=5.
    task automatic test_continuous_stop();
        logic       exp_tick;
        logic [2:0] exp_tap;
        configure(16'd3, 1'b0, 8'd0);
        do_start();
        for (int c = 1; c <= 21; c++) begin
            exp_tick = ((c % 4) == 0);
            exp_tap  = 3'((c - 1) / 4);
            checks++; if (bus.TICK !== exp_tick) begin fails++; $display("FAIL cont_tick c=%0d got %b exp %b", c, bus.TICK, exp_tick); end
            checks++; if (bus.TAP_OUT !== exp_tap) begin fails++; $display("FAIL cont_tap c=%0d got %0d exp %0d", c, bus.TAP_OUT, exp_tap); end
            checks++; if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL cont_busy c=%0d got %b exp 1", c, bus.BUSY); end
            if (c == 21) bus.STOP = 1'b1;
            step();
        end
        bus.STOP = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL stop_busy got %b exp 0", bus.BUSY); end
        checks++; if (bus.TAP_OUT !== 3'd5) begin fails++; $display("FAIL stop_tap got %0d exp 5", bus.TAP_OUT); end
        checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL stop_done got %b exp 0", bus.DONE); end
        checks++; if (bus.TICK !== 1'b0) begin fails++; $display("FAIL stop_tick got %b exp 0", bus.TICK); end
    endtask

    // TAP_OUT wrap plus CFG_VALID and START ignored during RUN.
    task automatic test_wrap_contention();
        logic       exp_tick;
        logic [2:0] exp_tap;
        do_start();
        for (int c = 1; c <= 34; c++) begin
            exp_tick = ((c % 4) == 0);
            exp_tap  = 3'((c - 1) / 4);
            checks++; if (bus.TICK !== exp_tick) begin fails++; $display("FAIL wrap_tick c=%0d got %b exp %b", c, bus.TICK, exp_tick); end
            checks++; if (bus.TAP_OUT !== exp_tap) begin fails++; $display("FAIL wrap_tap c=%0d got %0d exp %0d", c, bus.TAP_OUT, exp_tap); end
            checks++; if (bus.CFG_READY !== 1'b0) begin fails++; $display("FAIL wrap_ready c=%0d got %b exp 0", c, bus.CFG_READY); end
            idle_inputs();
            if (c == 9) begin
                bus.CFG_VALID = 1'b1;
                bus.CFG_DIV   = 16'd9;
            end
            if (c == 14) bus.START = 1'b1;
            step();
        end
        idle_inputs();
        do_stop();
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL wrap_stop_busy got %b exp 0", bus.BUSY); end
    endtask

    // DIV=1 one-shot of 3, configured in the START cycle.
    task automatic test_oneshot();
        logic exp_tick;
        bus.CFG_VALID = 1'b1;
        bus.CFG_DIV   = 16'd1;
        bus.CFG_MODE  = 1'b1;
        bus.CFG_COUNT = 8'd3;
        bus.START     = 1'b1;
        step();
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            exp_tick = ((c % 2) == 0);
            checks++; if (bus.TICK !== exp_tick) begin fails++; $display("FAIL os_tick c=%0d got %b exp %b", c, bus.TICK, exp_tick); end
            checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL os_done_early c=%0d got %b exp 0", c, bus.DONE); end
            step();
        end
        checks++; if (bus.DONE !== 1'b1) begin fails++; $display("FAIL os_done got %b exp 1", bus.DONE); end
        checks++; if (bus.TICK !== 1'b0) begin fails++; $display("FAIL os_done_tick got %b exp 0", bus.TICK); end
        checks++; if (bus.TAP_OUT !== 3'd3) begin fails++; $display("FAIL os_tap got %0d exp 3", bus.TAP_OUT); end
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL os_busy_after got %b exp 0", bus.BUSY); end
        checks++; if (bus.CFG_READY !== 1'b1) begin fails++; $display("FAIL os_ready_after got %b exp 1", bus.CFG_READY); end
        checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL os_done_after got %b exp 0", bus.DONE); end
        step();
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL os_idle_hold got %b exp 0", bus.BUSY); end
    endtask

    // DIV=0: TICK every RUN cycle; STOP on a tick still counts it.
    task automatic test_div0();
        logic [2:0] exp_tap;
        configure(16'd0, 1'b0, 8'd0);
        do_start();
        for (int c = 1; c <= 10; c++) begin
            exp_tap = 3'(c - 1);
            checks++; if (bus.TICK !== 1'b1) begin fails++; $display("FAIL div0_tick c=%0d got %b exp 1", c, bus.TICK); end
            checks++; if (bus.TAP_OUT !== exp_tap) begin fails++; $display("FAIL div0_tap c=%0d got %0d exp %0d", c, bus.TAP_OUT, exp_tap); end
            if (c == 10) bus.STOP = 1'b1;
            step();
        end
        bus.STOP = 1'b0;
        checks++; if (bus.TAP_OUT !== 3'd2) begin fails++; $display("FAIL div0_stop_tap got %0d exp 2", bus.TAP_OUT); end
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL div0_stop_busy got %b exp 0", bus.BUSY); end
    endtask

    // One-shot with count 0: DONE in cycle 1, no TICK.
    task automatic test_count0();
        bus.CFG_VALID = 1'b1;
        bus.CFG_DIV   = 16'd5;
        bus.CFG_MODE  = 1'b1;
        bus.CFG_COUNT = 8'd0;
        bus.START     = 1'b1;
        step();
        idle_inputs();
        checks++; if (bus.DONE !== 1'b1) begin fails++; $display("FAIL cnt0_done got %b exp 1", bus.DONE); end
        checks++; if (bus.TICK !== 1'b0) begin fails++; $display("FAIL cnt0_tick got %b exp 0", bus.TICK); end
        step();
        checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL cnt0_done_after got %b exp 0", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL cnt0_busy_after got %b exp 0", bus.BUSY); end
    endtask

    // START and STOP together in IDLE: no run begins.
    task automatic test_start_stop();
        configure(16'd0, 1'b0, 8'd0);
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL ss_busy c=%0d got %b exp 0", c, bus.BUSY); end
            checks++; if (bus.TICK !== 1'b0) begin fails++; $display("FAIL ss_tick c=%0d got %b exp 0", c, bus.TICK); end
            step();
        end
    endtask

    // RST in cycle 5 of a one-shot: back to IDLE, no DONE, TAP_OUT cleared.
    task automatic test_midrun_reset();
        configure(16'd1, 1'b1, 8'd5);
        do_start();
        for (int c = 1; c <= 4; c++) step();
        checks++; if (bus.TAP_OUT !== 3'd2) begin fails++; $display("FAIL mr_tap_pre got %0d exp 2", bus.TAP_OUT); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL mr_busy got %b exp 0", bus.BUSY); end
        checks++; if (bus.TAP_OUT !== 3'd0) begin fails++; $display("FAIL mr_tap got %0d exp 0", bus.TAP_OUT); end
        checks++; if (bus.CFG_READY !== 1'b1) begin fails++; $display("FAIL mr_ready got %b exp 1", bus.CFG_READY); end
        for (int c = 0; c < 8; c++) begin
            checks++; if (bus.DONE !== 1'b0) begin fails++; $display("FAIL mr_done c=%0d got %b exp 0", c, bus.DONE); end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_continuous_stop();
        test_wrap_contention();
        test_oneshot();
        test_div0();
        test_count0();
        test_start_stop();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Synchronous controller and sequencer for the Time_Manager divider chain.
- Holds a programmable divide ratio and starts or stops the time base.
- Emits a single-cycle TICK clock-enable each period, plus a LEVELs-bit synchronous tick counter (TAP_OUT) that replaces ripple-clocked divider taps with enables in the CLK_IN domain.
- Supports continuous and one-shot (N ticks) modes, with a valid/ready configuration handshake.

Parameters:
- CNT_W, 16, width of divide-ratio register and prescaler.
- LEVELs, 3, width of TAP_OUT tick counter.
- NCNT_W, 8, width of one-shot tick count.

Ports:
- CLK_IN  input  1  sole clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- CFG_VALID  input  1  configuration offer.
- CFG_READY  output  1  high exactly when state==IDLE.
- CFG_DIV  input  CNT_W  period minus one, in CLK_IN cycles.
- CFG_MODE  input  1  0 = continuous, 1 = one-shot.
- CFG_COUNT  input  NCNT_W  ticks to issue in one-shot mode.
- START  input  1  begin sequencing (honoured in IDLE only).
- STOP  input  1  abort sequencing.
- TICK  output  1  one-cycle enable per period.
- TAP_OUT  output  LEVELs  count of TICKs since START, wraps modulo 2^LEVELs.
- BUSY  output  1  state != IDLE.
- DONE  output  1  one-cycle pulse at one-shot completion.

Behaviour:
- One clock, CLK_IN. Reset is synchronous and active-high on RST; all state changes occur on the CLK_IN posedge.
- Reset values:
  - state=IDLE; div_reg=0; mode_reg=0; cnt_reg=0; prescaler=0; remaining=0.
  - TICK=0, TAP_OUT=0, DONE=0, BUSY=0, CFG_READY=1 (first cycle after RST deasserts).
- RST wins over every other input in the same cycle, including mid-RUN: the block returns to IDLE and emits no DONE.
- Config handshake:
  - CFG_VALID && CFG_READY at an edge loads div_reg, mode_reg and cnt_reg.
  - CFG_VALID while not ready is ignored; it is neither held nor queued.
- States: IDLE, RUN, DONE.
- IDLE:
  - START && !STOP -> RUN. Prescaler, TAP_OUT and remaining are cleared; remaining = cnt_reg.
  - If CFG_VALID and START are in the same cycle, the new config is loaded and used for this run.
  - START && STOP in the same cycle -> stay IDLE.
  - Mode 1 with count 0: START goes to DONE directly, no TICK is issued.
- RUN:
  - prescaler increments each cycle.
  - When prescaler == div_reg: TICK=1 that cycle, prescaler <= 0, TAP_OUT <= TAP_OUT+1 (wraps), remaining decrements in mode 1.
  - TICK is combinational from state and prescaler; TAP_OUT is registered.
- Latency: START sampled at edge k -> first TICK in cycle k+1+div_reg, then every div_reg+1 cycles. div_reg=0 gives TICK every RUN cycle.
- Mode 1: the cycle with TICK and remaining==1 -> DONE next edge. Exactly CFG_COUNT ticks are issued.
- STOP in RUN -> IDLE next edge.
  - No DONE; TAP_OUT holds its value.
  - A TICK coinciding with STOP is still issued that cycle.
- DONE state: DONE=1 for exactly one cycle, TICK=0, then IDLE unconditionally. START and STOP are ignored in DONE.
- Mode 0 never leaves RUN except on STOP or RST.
- Prescaler compare is unsigned, full CNT_W width. div_reg = 2^CNT_W-1 is legal, with no overflow beyond it.
- START while BUSY is ignored; config changes are impossible while BUSY.

Test Plan:
- Reset/idle: assert RST 2 cycles with all inputs toggling -> TICK=0, TAP_OUT=0, DONE=0, BUSY=0, CFG_READY=1 after release.
- Continuous, CFG_DIV=3, mode 0, START at cycle 0:
  - TICK in cycles 4, 8, 12, 16, 20, ...
  - TAP_OUT reads 1, 2, ..., 7, 0 (wraps after the 8th tick).
  - BUSY=1 throughout; STOP at cycle 21 -> IDLE at 22 with TAP_OUT=5 held.
- One-shot, CFG_DIV=1, CFG_COUNT=3, same-cycle CFG_VALID+START at cycle 0:
  - TICK in cycles 2, 4, 6; DONE=1 in cycle 7; BUSY=0 and CFG_READY=1 in cycle 8.
- Edge divides:
  - CFG_DIV=0, mode 0 -> TICK high every cycle from cycle 1.
  - CFG_COUNT=0, mode 1 -> no TICK, DONE in cycle 1.
- Contention:
  - START+STOP together in IDLE -> stays IDLE.
  - CFG_VALID with CFG_DIV=9 during RUN -> ignored; period unchanged at 4.
  - START during RUN -> no restart, TAP_OUT not cleared.
- Mid-run reset: RST asserted in cycle 5 of a one-shot -> IDLE next edge, DONE never pulses, TAP_OUT=0.
